// File: rtl/key_scanner.sv
// key_scanner: 4x4 matrix keypad scanner with whole-scan debouncing.
// Strobes one row per clock, gathers a full four-row scan, classifies it as
// none / single key / multiple keys, and debounces presses and releases
// over DEBOUNCE_SCANS consecutive scans before pulsing key_valid / key_release.
module key_scanner #(
    parameter int DEBOUNCE_SCANS = 3,
    parameter bit ACTIVE_LOW     = 1'b0
) (
    input  logic       clk190hz,
    input  logic       rst,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_release,
    output logic       key_held
);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    localparam logic [3:0] DS        = 4'(DEBOUNCE_SCANS);
    localparam logic [3:0] ROW_RESET = ACTIVE_LOW ? 4'b1110 : 4'b0001;

    state_t      state;
    logic [1:0]  scan_idx;
    logic [1:0]  next_idx;
    logic [11:0] scan_acc;
    logic [3:0]  cnt;
    logic [3:0]  cand;
    logic [3:0]  cnt_inc;
    logic [3:0]  col_on;
    logic [3:0]  next_onehot;
    logic [15:0] scan_keys;
    logic [4:0]  key_count;
    logic [3:0]  single_code;
    logic        is_single;
    logic        match;
    logic        scan_end;

    assign col_on      = ACTIVE_LOW ? ~col : col;
    assign next_idx    = scan_idx + 2'd1;
    assign next_onehot = 4'b0001 << next_idx;
    assign scan_end    = (scan_idx == 2'd3);
    assign scan_keys   = {col_on, scan_acc};
    assign cnt_inc     = (cnt < DS) ? cnt + 4'd1 : cnt;

    // Classify the scan that completes on this edge: count keys and remember the code of the last one seen
    always_comb begin
        key_count   = 5'd0;
        single_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (scan_keys[i]) begin
                key_count   = key_count + 5'd1;
                single_code = 4'(i);
            end
        end
        is_single = (key_count == 5'd1);
        match     = is_single && (single_code == cand);
    end

    // Row strobe sequencer and per-row column capture for rows 0..2 (row 3 is used live at scan end)
    always_ff @(posedge clk190hz) begin
        if (rst) begin
            scan_idx <= 2'd0;
            row      <= ROW_RESET;
            scan_acc <= 12'd0;
        end else begin
            scan_idx <= next_idx;
            row      <= ACTIVE_LOW ? ~next_onehot : next_onehot;
            case (scan_idx)
                2'd0:    scan_acc[3:0]  <= col_on;
                2'd1:    scan_acc[7:4]  <= col_on;
                2'd2:    scan_acc[11:8] <= col_on;
                default: scan_acc       <= scan_acc;
            endcase
        end
    end

    // Debounce FSM, stepping once per completed scan, with registered pulses and held level
    always_ff @(posedge clk190hz) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            cand        <= 4'd0;
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            key_held    <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            if (scan_end) begin
                case (state)
                    IDLE: begin
                        if (is_single) begin
                            cand <= single_code;
                            if (DS == 4'd1) begin
                                state     <= PRESSED;
                                key_code  <= single_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= 4'd0;
                            end else begin
                                state <= DEBOUNCE;
                                cnt   <= 4'd1;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (match) begin
                            if (cnt_inc == DS) begin
                                state     <= PRESSED;
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= 4'd0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            state <= IDLE;
                            cnt   <= 4'd0;
                        end
                    end
                    PRESSED: begin
                        if (!match) begin
                            if (DS == 4'd1) begin
                                state       <= IDLE;
                                key_release <= 1'b1;
                                key_held    <= 1'b0;
                                cnt         <= 4'd0;
                            end else begin
                                state <= RELEASE;
                                cnt   <= 4'd1;
                            end
                        end
                    end
                    RELEASE: begin
                        if (match) begin
                            state <= PRESSED;
                            cnt   <= 4'd0;
                        end else if (cnt_inc == DS) begin
                            state       <= IDLE;
                            key_release <= 1'b1;
                            key_held    <= 1'b0;
                            cnt         <= 4'd0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_scanner.sv
// tb_key_scanner: directed and random keypad patterns checked against a
// scan-level model of the debounce rules.
module tb_key_scanner;

    localparam int DS = 3;

    logic        clk190hz;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_release;
    logic        key_held;

    logic [15:0] keys;

    int total;
    int bad;
    int scanPos;

    logic       expValid;
    logic       expRel;
    logic       mHeld;
    logic [3:0] mCand;
    logic [3:0] mCode;
    int         mStreak;

    key_scanner #(
        .DEBOUNCE_SCANS(DS),
        .ACTIVE_LOW    (1'b0)
    ) dut (
        .clk190hz   (clk190hz),
        .rst        (rst),
        .row        (row),
        .col        (col),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_release(key_release),
        .key_held   (key_held)
    );

    // Scan clock
    initial clk190hz = 1'b0;
    always #5 clk190hz = ~clk190hz;

    // Keypad matrix: columns report the pressed keys of whichever row is strobed
    always_comb begin
        col = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (row[i]) col = col | keys[i*4 +: 4];
        end
    end

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scan-level model: one call per complete scan with the pressed-key set
    task automatic modelScan(input logic [15:0] k);
        int     n;
        int     code;
        logic   single;
        logic   same;
        n    = $countones(k);
        code = 0;
        for (int i = 0; i < 16; i++) if (k[i]) code = i;
        single   = (n == 1);
        same     = single && (4'(code) == mCand);
        expValid = 1'b0;
        expRel   = 1'b0;
        if (!mHeld) begin
            if (mStreak > 0) begin
                if (same) mStreak++;
                else      mStreak = 0;
            end else if (single) begin
                mCand   = 4'(code);
                mStreak = 1;
            end
            if (mStreak >= DS) begin
                expValid = 1'b1;
                mHeld    = 1'b1;
                mCode    = mCand;
                mStreak  = 0;
            end
        end else begin
            if (same) begin
                mStreak = 0;
            end else begin
                mStreak++;
                if (mStreak >= DS) begin
                    expRel  = 1'b1;
                    mHeld   = 1'b0;
                    mStreak = 0;
                end
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("row",         row,                4'b0001 << scanPos);
        checkOutput("key_valid",   {3'b000, key_valid},   {3'b000, expValid});
        checkOutput("key_release", {3'b000, key_release}, {3'b000, expRel});
        checkOutput("key_held",    {3'b000, key_held},    {3'b000, mHeld});
        checkOutput("key_code",    key_code,           mCode);
    endtask

    // Drive a key set for nEdges clocks; the model steps whenever a scan completes
    task automatic applyStimulus(input logic [15:0] k, input int nEdges = 4);
        keys = k;
        for (int j = 0; j < nEdges; j++) begin
            @(posedge clk190hz);
            #1;
            scanPos  = (scanPos + 1) % 4;
            expValid = 1'b0;
            expRel   = 1'b0;
            if (scanPos == 0) modelScan(k);
            checkAll();
        end
    endtask

    task automatic applyReset();
        rst = 1'b1;
        @(posedge clk190hz);
        #1;
        scanPos  = 0;
        expValid = 1'b0;
        expRel   = 1'b0;
        mHeld    = 1'b0;
        mCand    = 4'd0;
        mCode    = 4'd0;
        mStreak  = 0;
        checkAll();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] cur;
        int          pick;
        total = 0;
        bad   = 0;
        keys  = 16'h0000;
        rst   = 1'b1;
        scanPos = 0;
        @(posedge clk190hz);
        #1;
        applyReset();

        $display("[TB] idle scanning");
        for (int n = 0; n < 10; n++) applyStimulus(16'h0000);

        $display("[TB] key 9 press and release");
        applyReset();
        for (int n = 0; n < 5; n++) applyStimulus(16'h0200);
        for (int n = 0; n < 4; n++) applyStimulus(16'h0000);

        $display("[TB] key 5 bounce");
        applyStimulus(16'h0020);
        applyStimulus(16'h0000);
        for (int n = 0; n < 3; n++) applyStimulus(16'h0020);
        for (int n = 0; n < 4; n++) applyStimulus(16'h0000);

        $display("[TB] keys 0 and 15 together");
        for (int n = 0; n < 4; n++) applyStimulus(16'h8001);
        for (int n = 0; n < 4; n++) applyStimulus(16'h0001);
        for (int n = 0; n < 4; n++) applyStimulus(16'h0000);

        $display("[TB] held key drops out for two scans");
        for (int n = 0; n < 3; n++) applyStimulus(16'h0200);
        applyStimulus(16'h0000);
        applyStimulus(16'h0000);
        for (int n = 0; n < 3; n++) applyStimulus(16'h0200);

        $display("[TB] reset during debounce");
        for (int n = 0; n < 4; n++) applyStimulus(16'h0000);
        applyStimulus(16'h0008);
        applyStimulus(16'h0008);
        applyStimulus(16'h0008, 2);
        applyReset();
        for (int n = 0; n < 4; n++) applyStimulus(16'h0008);
        for (int n = 0; n < 4; n++) applyStimulus(16'h0000);

        $display("[TB] random key patterns");
        cur = 16'h0000;
        for (int n = 0; n < 120; n++) begin
            pick = $urandom_range(0, 9);
            if (pick == 6)      cur = 16'h0000;
            else if (pick < 9 && pick > 6) cur = 16'h0001 << $urandom_range(0, 15);
            else if (pick == 9) cur = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            applyStimulus(cur);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
